// File: rtl/rand_dealer_pkg.sv
// rand_dealer_pkg: shared dealer states, default card constants and card type.
package rand_dealer_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_MAX_CARD = 13;
  localparam int DEF_MAX_TRIES = 8;
  typedef enum logic [1:0] {IDLE, PRIME, DRAW, DONE} state_t;
  typedef logic [DEF_WIDTH-1:0] card_t;
endpackage

// File: rtl/rand_dealer_if.sv
// rand_dealer_if: random-source and hand signals between dealer and game logic.
interface rand_dealer_if #(parameter int WIDTH = 4);
  logic deal, rand_en, hand_valid, busy, done, fallback_used;
  logic [WIDTH-1:0] rand_in, card0, card1, card2, card3;
  modport master(input deal, rand_in, output rand_en, card0, card1, card2, card3, hand_valid, busy, done, fallback_used);
  modport slave(output deal, rand_in, input rand_en, card0, card1, card2, card3, hand_valid, busy, done, fallback_used);
endinterface

// File: rtl/rand_dealer_accept.sv
// card_accept: combinational legal-card range check (1..MAX_CARD).
module card_accept #(
  parameter int WIDTH = 4,
  parameter int MAX_CARD = 13
) (
  input  logic [WIDTH-1:0] v,
  output logic             accept
);
  assign accept = (v != '0) && (v <= WIDTH'(MAX_CARD));
endmodule

// File: rtl/rand_dealer.sv
// rand_dealer: rejection-samples a random nibble source into a four-card hand.
module rand_dealer
  import rand_dealer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX_CARD = DEF_MAX_CARD,
  parameter int MAX_TRIES = DEF_MAX_TRIES
) (
  input logic          clk,
  input logic          rst,
  rand_dealer_if.master bus
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  state_t state;
  logic [1:0] slot;
  logic [TW-1:0] tries;
  logic [WIDTH-1:0] cards [4];
  logic ok, give_up;
  logic [WIDTH-1:0] val;
  card_accept #(.WIDTH(WIDTH), .MAX_CARD(MAX_CARD)) u_accept (.v(bus.rand_in), .accept(ok));
  // A stuck or out-of-range source still yields a legal, distinct-per-slot card.
  assign give_up = !ok && (tries == TW'(MAX_TRIES - 1));
  assign val = ok ? bus.rand_in : WIDTH'(slot) + WIDTH'(1);
  assign bus.card0 = cards[0];
  assign bus.card1 = cards[1];
  assign bus.card2 = cards[2];
  assign bus.card3 = cards[3];
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      slot <= '0;
      tries <= '0;
      cards <= '{default: '0};
      bus.hand_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.fallback_used <= 1'b0;
      bus.rand_en <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.deal) begin
          state <= PRIME;
          slot <= '0;
          tries <= '0;
          bus.hand_valid <= 1'b0;
          bus.fallback_used <= 1'b0;
          bus.busy <= 1'b1;
          bus.rand_en <= 1'b1;
        end
        PRIME: state <= DRAW;
        DRAW: if (ok || give_up) begin
          cards[slot] <= val;
          tries <= '0;
          slot <= slot + 2'd1;
          if (give_up) bus.fallback_used <= 1'b1;
          if (slot == 2'd3) begin
            state <= DONE;
            bus.rand_en <= 1'b0;
            bus.done <= 1'b1;
          end
        end else begin
          tries <= tries + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          bus.hand_valid <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rand_dealer.sv
// tb_rand_dealer: directed scenarios for rand_dealer with a scripted or LFSR source.
module tb_rand_dealer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  rand_dealer_if #(.WIDTH(4)) ifc();
  rand_dealer dut (.clk(clk), .rst(rst), .bus(ifc));
  always #5 clk = ~clk;
  logic [3:0] seq [64];
  logic [3:0] lfsr;
  bit lfsr_mode;
  int idx, checks, errors;
  logic [3:0] got [4];
  logic [3:0] exp_c [4];
  // Generator model: advances once per clock edge on which rand_en was high.
  task automatic step();
    if (lfsr_mode) begin
      lfsr = {lfsr[2:0], ~(lfsr[3] ^ lfsr[2])};
      ifc.rand_in = lfsr;
    end else begin
      idx++;
      ifc.rand_in = seq[idx];
    end
  endtask
  task automatic run_hand(input bit hold, input int pulse_at, input int limit, output int d1, output int d2, output int en_cnt);
    bit en_prev;
    d1 = -1; d2 = -1; en_cnt = 0; en_prev = 1'b0;
    @(negedge clk);
    idx = 0; lfsr = '0;
    ifc.rand_in = lfsr_mode ? lfsr : seq[0];
    ifc.deal = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == pulse_at) ifc.deal = 1'b1; else if (!hold) ifc.deal = 1'b0;
      if (en_prev) step();
      en_prev = ifc.rand_en;
      if (ifc.rand_en) en_cnt++;
      if (ifc.done) begin
        if (d1 < 0) d1 = c; else d2 = c;
        if (!hold || d2 >= 0) break;
      end
    end
    ifc.deal = 1'b0;
  endtask
  task automatic check_cards(input string name);
    got = '{ifc.card0, ifc.card1, ifc.card2, ifc.card3};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_c[i]) begin errors++; $display("FAIL %s card%0d got %0d want %0d", name, i, got[i], exp_c[i]); end
    end
  endtask
  task automatic check_after_done(input string name, input bit fb);
    checks++;
    if (ifc.hand_valid !== 1'b0) begin errors++; $display("FAIL %s hand_valid during done got %b want 0", name, ifc.hand_valid); end
    checks++;
    if (ifc.fallback_used !== fb) begin errors++; $display("FAIL %s fallback_used got %b want %b", name, ifc.fallback_used, fb); end
    @(negedge clk);
    checks++;
    if ({ifc.done, ifc.hand_valid, ifc.busy, ifc.rand_en} !== 4'b0100) begin
      errors++; $display("FAIL %s post-done {done,hv,busy,en} got %b want 0100", name, {ifc.done, ifc.hand_valid, ifc.busy, ifc.rand_en});
    end
  endtask
  task automatic test_reset();
    rst = 1'b0; ifc.deal = 1'b0; ifc.rand_in = '0; lfsr_mode = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.card0, ifc.card1, ifc.card2, ifc.card3, ifc.hand_valid, ifc.busy, ifc.done, ifc.fallback_used, ifc.rand_en} !== 21'd0) begin
      errors++; $display("FAIL reset outputs got %h want 0", {ifc.card0, ifc.card1, ifc.card2, ifc.card3, ifc.hand_valid, ifc.busy, ifc.done, ifc.fallback_used, ifc.rand_en});
    end
    rst = 1'b1;
  endtask
  task automatic test_happy();
    int d1, d2, en;
    seq[0] = 0; seq[1] = 3; seq[2] = 7; seq[3] = 12; seq[4] = 1;
    run_hand(1'b0, 0, 60, d1, d2, en);
    checks++;
    if (d1 !== 6) begin errors++; $display("FAIL happy latency got %0d want 6", d1); end
    exp_c = '{3, 7, 12, 1};
    check_cards("happy");
    check_after_done("happy", 1'b0);
  endtask
  task automatic test_reject();
    int d1, d2, en;
    seq[0] = 0; seq[1] = 0; seq[2] = 14; seq[3] = 15; seq[4] = 5; seq[5] = 9; seq[6] = 13; seq[7] = 2;
    run_hand(1'b0, 0, 60, d1, d2, en);
    checks++;
    if (d1 !== 9) begin errors++; $display("FAIL reject latency got %0d want 9", d1); end
    exp_c = '{5, 9, 13, 2};
    check_cards("reject");
    check_after_done("reject", 1'b0);
  endtask
  task automatic test_stuck();
    int d1, d2, en;
    for (int i = 0; i < 64; i++) seq[i] = 4'hF;
    run_hand(1'b0, 0, 80, d1, d2, en);
    checks++;
    if (d1 !== 34) begin errors++; $display("FAIL stuck latency got %0d want 34", d1); end
    checks++;
    if (en !== 33) begin errors++; $display("FAIL stuck rand_en cycles got %0d want 33", en); end
    exp_c = '{1, 2, 3, 4};
    check_cards("stuck");
    check_after_done("stuck", 1'b1);
  endtask
  task automatic test_deal_ignored();
    int d1, d2, en;
    seq[0] = 0; seq[1] = 3; seq[2] = 7; seq[3] = 12; seq[4] = 1;
    run_hand(1'b0, 3, 60, d1, d2, en);
    checks++;
    if (d1 !== 6) begin errors++; $display("FAIL ignore latency got %0d want 6", d1); end
    exp_c = '{3, 7, 12, 1};
    check_cards("ignore");
    check_after_done("ignore", 1'b0);
    @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL ignore restart busy got %b want 0", ifc.busy); end
  endtask
  task automatic test_back_to_back();
    int d1, d2, en;
    seq[0] = 0; seq[1] = 3; seq[2] = 7; seq[3] = 12; seq[4] = 1;
    seq[5] = 0; seq[6] = 4; seq[7] = 5; seq[8] = 6; seq[9] = 8;
    run_hand(1'b1, 0, 60, d1, d2, en);
    checks++;
    if (d1 !== 6 || d2 !== 13) begin errors++; $display("FAIL b2b done cycles got %0d,%0d want 6,13", d1, d2); end
    exp_c = '{4, 5, 6, 8};
    check_cards("b2b");
    check_after_done("b2b", 1'b0);
  endtask
  task automatic test_reset_mid_draw();
    int d1, d2, en;
    bit en_prev;
    seq[0] = 0; seq[1] = 3; seq[2] = 7; seq[3] = 12; seq[4] = 1;
    @(negedge clk);
    idx = 0; ifc.rand_in = seq[0]; ifc.deal = 1'b1; en_prev = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      ifc.deal = 1'b0;
      if (en_prev) step();
      en_prev = ifc.rand_en;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc.card0, ifc.card1, ifc.card2, ifc.card3, ifc.hand_valid, ifc.busy, ifc.done, ifc.fallback_used, ifc.rand_en} !== 21'd0) begin
      errors++; $display("FAIL midreset outputs got %h want 0", {ifc.card0, ifc.card1, ifc.card2, ifc.card3, ifc.hand_valid, ifc.busy, ifc.done, ifc.fallback_used, ifc.rand_en});
    end
    rst = 1'b1;
    run_hand(1'b0, 0, 60, d1, d2, en);
    checks++;
    if (d1 !== 6) begin errors++; $display("FAIL midreset latency got %0d want 6", d1); end
    exp_c = '{3, 7, 12, 1};
    check_cards("midreset");
  endtask
  task automatic test_lfsr();
    int d1, d2, en;
    lfsr_mode = 1'b1;
    run_hand(1'b0, 0, 60, d1, d2, en);
    lfsr_mode = 1'b0;
    checks++;
    if (d1 !== 7) begin errors++; $display("FAIL lfsr latency got %0d want 7", d1); end
    checks++;
    if (en !== 6) begin errors++; $display("FAIL lfsr rand_en cycles got %0d want 6", en); end
    exp_c = '{1, 3, 7, 13};
    check_cards("lfsr");
    check_after_done("lfsr", 1'b0);
  endtask
  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_happy();
    test_reject();
    test_stuck();
    test_deal_ignored();
    test_back_to_back();
    test_reset_mid_draw();
    test_lfsr();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
